// File: rtl/minsec_display.sv
// rtl/minsec_display.sv - multiplexed MM.SS 7-segment driver with adjust-mode blinking.
module minsec_display #(
  parameter int BASE_CLK = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] MINUTES,
  input  logic [5:0] SECONDS,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       DP
);

  localparam int N  = BASE_CLK / SCAN_HZ;
  localparam int H  = BASE_CLK / (2 * BLINK_HZ);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(N - 1);
  localparam logic [HW-1:0] BLINK_LAST = HW'(H - 1);
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    digit_q, digit_d;
  logic [5:0]    min_snap_q, min_snap_d;
  logic [5:0]    sec_snap_q, sec_snap_d;
  logic [HW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [5:0] pair_val;
  logic [5:0] digit_val;
  logic       blank;

  function automatic logic [6:0] seg7(input logic [5:0] v);
    case (v)
      6'd0:    seg7 = 7'b1000000;
      6'd1:    seg7 = 7'b1111001;
      6'd2:    seg7 = 7'b0100100;
      6'd3:    seg7 = 7'b0110000;
      6'd4:    seg7 = 7'b0011001;
      6'd5:    seg7 = 7'b0010010;
      6'd6:    seg7 = 7'b0000010;
      6'd7:    seg7 = 7'b1111000;
      6'd8:    seg7 = 7'b0000000;
      6'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_OFF;
    endcase
  endfunction

  always_comb begin
    slot_d      = slot_q;
    digit_d     = digit_q;
    min_snap_d  = min_snap_q;
    sec_snap_d  = sec_snap_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    an_d        = 4'b1111;
    seg_d       = SEG_OFF;
    dp_d        = 1'b1;

    if (slot_q == SLOT_LAST) begin
      slot_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      slot_d = slot_q + 1'b1;
    end

    // One snapshot per full scan keeps all four digits consistent.
    if (slot_q == '0 && digit_q == 2'd0) begin
      min_snap_d = MINUTES;
      sec_snap_d = SECONDS;
    end

    if (!ADJ) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    pair_val  = digit_q[1] ? min_snap_q : sec_snap_q;
    digit_val = digit_q[0] ? (pair_val / 6'd10) : (pair_val % 6'd10);
    blank     = ADJ && !blink_on_q && (digit_q[1] == SEL);

    // Slot-cycle 0 stays dark so the anode switch never ghosts the previous digit.
    if (slot_q != '0) begin
      an_d[digit_q] = 1'b0;
      if (blank)
        seg_d = SEG_OFF;
      else if (pair_val >= 6'd60)
        seg_d = SEG_DASH;
      else
        seg_d = seg7(digit_val);
      dp_d = !(digit_q == 2'd2 && !blank);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q      <= '0;
      digit_q     <= 2'd0;
      min_snap_q  <= 6'd0;
      sec_snap_q  <= 6'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      slot_q      <= slot_d;
      digit_q     <= digit_d;
      min_snap_q  <= min_snap_d;
      sec_snap_q  <= sec_snap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_minsec_display.sv
// tb/tb_minsec_display.sv - scoreboard bench for minsec_display against a time-indexed reference model.
module tb_minsec_display;

  localparam int N = 4;
  localparam int H = 20;
  localparam logic [11:0] BLANK = {4'b1111, 7'b1111111, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];

  logic [6:0] enc_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  minsec_display #(.BASE_CLK(40), .SCAN_HZ(10), .BLINK_HZ(1)) dut (
    .i_clk(clk), .i_rst(rst), .MINUTES(minutes), .SECONDS(seconds),
    .ADJ(adj), .SEL(sel), .SEG(seg), .AN(an), .DP(dp)
  );

  always #5 clk = ~clk;

  // k = cycles since reset release, r = consecutive cycles with ADJ high.
  function automatic logic [11:0] model_out(int k, int sm, int ss, int r, logic a, logic s);
    int slot, d, v, dg;
    logic blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    slot = k % N;
    d    = (k / N) % 4;
    if (slot == 0) return BLANK;
    v  = (d >= 2) ? sm : ss;
    dg = (d % 2 == 1) ? v / 10 : v % 10;
    blank = a && (((r / H) % 2) == 1) && ((d >= 2) == s);
    e_an = 4'b1111;
    e_an[d] = 1'b0;
    if (blank) e_seg = 7'b1111111;
    else if (v >= 60) e_seg = 7'b0111111;
    else e_seg = enc_tbl[dg];
    e_dp = !(d == 2 && !blank);
    return {e_an, e_seg, e_dp};
  endfunction

  initial begin : model
    int k, sm, ss, r;
    k = 0; sm = 0; ss = 0; r = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0; sm = 0; ss = 0; r = 0;
        exp_q.push_back(BLANK);
      end else begin
        exp_q.push_back(model_out(k, sm, ss, r, adj, sel));
        if (k % (4 * N) == 0) begin
          sm = int'(minutes);
          ss = int'(seconds);
        end
        r = adj ? r + 1 : 0;
        k++;
      end
    end
  end

  initial begin : monitor
    logic [11:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      g = {an, seg, dp};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty at %0t: got an=%b seg=%b dp=%b", $time, an, seg, dp);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL display at %0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   $time, an, seg, dp, e[11:8], e[7:1], e[0]);
        end
      end
    end
  end

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic drive(input int m, input int s, input logic a, input logic sl);
    @(negedge clk);
    minutes = 6'(m);
    seconds = 6'(s);
    adj = a;
    sel = sl;
  endtask

  initial begin : stimulus
    int guard;
    drive(12, 34, 1'b0, 1'b0);
    run(3);
    rst = 1'b0;
    run(40);
    // Seconds change during the minutes-ones slot must wait for the next scan.
    guard = 0;
    while (!(an == 4'b1011) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    seconds = 6'd35;
    run(40);

    drive(61, 7, 1'b0, 1'b0);
    run(40);

    drive(5, 9, 1'b1, 1'b0);
    run(100);
    drive(5, 9, 1'b0, 1'b0);
    run(20);

    drive(5, 9, 1'b1, 1'b1);
    run(30);
    drive(5, 9, 1'b1, 1'b0);
    run(50);
    drive(5, 9, 1'b0, 1'b0);

    guard = 0;
    do begin
      @(posedge clk);
      #3;
      guard++;
    end while (an != 4'b1101 && guard < 100);
    tests++;
    if (guard >= 100) begin
      fails++;
      $display("FAIL wait_an1101: an=%b never reached 1101", an);
    end
    rst = 1'b1;
    minutes = 6'd42;
    seconds = 6'd18;
    #1;
    tests++;
    if ({an, seg, dp} !== BLANK) begin
      fails++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(40);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) minutes = 6'($urandom_range(63));
      if ($urandom_range(15) == 0) seconds = 6'($urandom_range(63));
      if ($urandom_range(63) == 0) adj = ~adj;
      if ($urandom_range(31) == 0) sel = ~sel;
      if ($urandom_range(999) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({an, seg, dp} !== BLANK) begin
          fails++;
          $display("FAIL async_reset_rand: got an=%b seg=%b dp=%b", an, seg, dp);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    run(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/minsec_display.md
MINSEC_DISPLAY -- requirements
Module: minsec_display

Interface
REQ-001 Parameter BASE_CLK, default 100_000_000: input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000: digit-slot rate in Hz; slot length N = BASE_CLK/SCAN_HZ cycles, N >= 2.
REQ-003 Parameter BLINK_HZ, default 2: blink rate in Hz; half-period H = BASE_CLK/(2*BLINK_HZ) cycles, H >= 1.
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 MINUTES  input  6  binary minutes count from the clock counter.
REQ-007 SECONDS  input  6  binary seconds count from the clock counter.
REQ-008 ADJ  input  1  adjust mode active.
REQ-009 SEL  input  1  adjust target: 1 = minutes, 0 = seconds.
REQ-010 SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 AN  output  4  digit anodes, active-low; AN[3] = minutes tens, AN[2] = minutes ones, AN[1] = seconds tens, AN[0] = seconds ones.
REQ-012 DP  output  1  decimal point, active-low.

Function
REQ-013 Slot counter counts 0..N-1 and wraps; digit index (0..3) increments on each wrap, 3 -> 0.
REQ-014 Slot-cycle 0 of every slot is a ghosting guard: AN=1111, SEG=1111111, DP=1.
REQ-015 Slot-cycles 1..N-1: exactly one AN bit low, selecting the current digit index; scan order AN[0], AN[1], AN[2], AN[3], repeat.
REQ-016 All outputs are registered and show the state of the previous cycle (one-cycle latency).
REQ-017 Snapshot registers capture MINUTES and SECONDS in slot-cycle 0 of digit 0 only; all four digits of one scan show one snapshot.
REQ-018 Tens = value/10, ones = value%10, computed from the snapshot; no divider state spans cycles.
REQ-019 A snapshot value in 60..63 shows dash (SEG=0111111) on both digits of that pair.
REQ-020 Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 DP=0 only while AN[2] is active, marking the MM.SS separator; DP=1 otherwise.
REQ-022 Blink counter counts 0..H-1; on wrap, blink phase toggles between on and off.
REQ-023 While ADJ=0, blink counter is held at 0 and phase is forced to on.
REQ-024 ADJ=1 with phase off: digits of the selected pair (SEL=1 -> AN[3:2], SEL=0 -> AN[1:0]) drive SEG=1111111 and DP=1; AN still asserts normally.
REQ-025 ADJ=1 with phase on, or digits of the unselected pair: normal display.
REQ-026 SEL changes take effect at the next slot-cycle; they do not reset blink phase.
REQ-027 ADJ 0 -> 1 starts with phase on and a full H cycles before the first off phase.

Reset
REQ-028 While i_rst=1: AN=1111, SEG=1111111, DP=1, slot counter=0, digit index=0, snapshots=0, blink counter=0, phase=on.
REQ-029 Reset assertion mid-slot or mid-blink forces all outputs to reset values immediately, with no clock edge required.
REQ-030 After reset deassertion, the first slot is digit 0; its slot-cycle 0 captures a snapshot.

Verification (BASE_CLK=40, SCAN_HZ=10 -> N=4; BLINK_HZ=1 -> H=20)
REQ-031 MINUTES=12, SECONDS=34, ADJ=0 -> repeating AN 1111,1110x3,1111,1101x3,1111,1011x3,1111,0111x3; SEG 0011001, 0110000, 0100100, 1111001; DP=0 only with AN=1011.
REQ-032 Change SECONDS 34 -> 35 during the AN[2] slot -> AN[1:0] still show 3,4 until the next digit-0 slot, then show 5 (0010010).
REQ-033 MINUTES=61, SECONDS=07 -> AN[3:2] show dash 0111111; AN[1:0] show 0,7.
REQ-034 ADJ=1, SEL=0, MINUTES=5, SECONDS=9 -> minutes digits always lit; seconds digits lit for 20 cycles, blank for 20, alternating; ADJ -> 0 restores seconds within one slot.
REQ-035 ADJ=1, SEL=1 -> AN[3:2] blink and DP blanks in off phase; toggle SEL mid-phase -> blinking moves to AN[1:0] without phase restart.
REQ-036 Assert i_rst asynchronously mid-slot with AN=1101 -> AN=1111, SEG=1111111, DP=1 before the next edge; after release, scan restarts at AN[0] showing the new snapshot.
